// File: rtl/uart_tx.sv
// UART transmitter: 8-N-1 / 8-E/O-1 frames, LSB first, with a one-byte holding
// register so the next byte can be queued while the current frame shifts out.
module uart_tx #(
  parameter int BIT_TIME = 40
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PARITY_EN,
  input  logic       PARITY_ODD,
  input  logic [7:0] DATA,
  input  logic       EN,
  output logic       READY,
  output logic       BUSY,
  output logic       DONE,
  output logic       TX
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t     state;
  logic       hold_full;
  logic [7:0] hold_q;
  logic [7:0] shift_q;
  logic       par_bit;
  logic       par_en;
  logic [8:0] cnt;
  logic [2:0] bit_cnt;
  logic       tx_q;
  logic       done_q;
  logic       bit_tick;
  logic       frame_start;

  function automatic logic parity_of(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

  assign bit_tick    = (cnt == 9'(BIT_TIME - 1));
  // A queued byte starts either from idle or on the very edge that ends a stop bit.
  assign frame_start = hold_full && ((state == S_IDLE) || ((state == S_STOP) && bit_tick));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_IDLE;
      hold_full <= 1'b0;
      par_en    <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == S_STOP) && bit_tick;

      if ((state == S_IDLE) || bit_tick) cnt <= '0;
      else                               cnt <= cnt + 9'd1;

      if (frame_start) hold_full <= 1'b0;
      else if (EN)     hold_full <= 1'b1;

      if (frame_start) begin
        state   <= S_START;
        tx_q    <= 1'b0;
        bit_cnt <= '0;
        par_en  <= PARITY_EN;
      end else if (bit_tick) begin
        case (state)
          S_START: begin
            state <= S_DATA;
            tx_q  <= shift_q[0];
          end
          S_DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (par_en) begin
                state <= S_PARITY;
                tx_q  <= par_bit;
              end else begin
                state <= S_STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              tx_q <= shift_q[1];
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            tx_q  <= 1'b1;
          end
          S_STOP: begin
            state <= S_IDLE;
            tx_q  <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Payload registers carry no reset; hold_full qualifies their contents.
  always_ff @(posedge CLK) begin
    if (EN && !hold_full) hold_q <= DATA;
    if (frame_start) begin
      shift_q <= hold_q;
      par_bit <= parity_of(hold_q, PARITY_ODD);
    end else if ((state == S_DATA) && bit_tick) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  assign READY = ~hold_full;
  assign BUSY  = (state != S_IDLE);
  assign DONE  = done_q;
  assign TX    = tx_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that converts bytes into 8-N-1 or 8-E/O-1 frames on a single TX line. It sits beside the UART receiver in the peripheral subsystem and shares its bit-time parameter and parity controls, so a transmitter–receiver pair with matching settings forms a loopback-compatible link. A one-byte holding register lets the CPU side queue the next byte while the current frame is shifting out, which allows back-to-back frames with no idle gap.

## Interface

Parameters:
- BIT_TIME, default 40: clock cycles per serial bit. Legal range is 2..511.

Ports:
- CLK, input, 1: system clock, rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- PARITY_EN, input, 1: 1 inserts a parity bit between the data bits and the stop bit.
- PARITY_ODD, input, 1: 1 selects odd parity, 0 selects even. Ignored when PARITY_EN = 0.
- DATA, input, 8: byte to send. Sampled when EN & READY.
- EN, input, 1: write strobe for one cycle. It is accepted only when READY = 1.
- READY, output, 1: holding register is empty and a write will be accepted.
- BUSY, output, 1: a frame is in progress (FSM state is not IDLE).
- DONE, output, 1: one-cycle pulse in the cycle after the stop bit completes.
- TX, output, 1: serial line. It is driven from a flop and idles high.

## Operation

- Holding register:
  - An accepted write (EN & READY at a rising edge) loads DATA and sets `hold_full`.
  - READY = ~hold_full.
  - EN while READY = 0 is ignored and the stored byte is unchanged.
- Shift register (8 bits):
  - Loaded from the holding register on a frame start; the same edge clears `hold_full`.
  - Shifts right, so bits go out LSB first.
- Parity bit:
  - Value = (^byte) ^ PARITY_ODD.
  - Computed and latched together with PARITY_EN at frame start, so later changes to these inputs do not affect a frame already in progress.
  - The resulting frames pass a receiver whose parity check starts from PARITY_ODD and XORs in the data and parity bits.
- Bit-time counter:
  - 9 bits; counts 0..BIT_TIME-1 while BUSY.
  - `bit_tick` = (count == BIT_TIME-1). On `bit_tick` the counter wraps to 0.
  - The counter is held at 0 in IDLE.
- Data-bit counter: 3 bits, cleared at frame start, incremented on each `bit_tick` in DATA.
- FSM states and transitions:
  - IDLE: if hold_full, perform frame start and go to START. Otherwise stay.
  - START: TX = 0. On `bit_tick`, go to DATA.
  - DATA: TX = shift[0]. On `bit_tick`, shift. If the bit count is 7, go to PARITY when the latched PARITY_EN = 1, otherwise go to STOP.
  - PARITY: TX = latched parity bit. On `bit_tick`, go to STOP.
  - STOP: TX = 1. On `bit_tick`, assert DONE for the next cycle. If hold_full, perform frame start and go directly to START; otherwise go to IDLE.
- Simultaneous write and frame start: a write cannot coincide with the holding-to-shift transfer because READY = 0 in that cycle. A write in the cycle after the transfer is accepted normally.
- Reset (asynchronous, including mid-frame):
  - State = IDLE, hold_full = 0, all counters = 0.
  - TX = 1, READY = 1, BUSY = 0, DONE = 0.
  - The aborted frame is truncated and no DONE is produced for it.

## Timing

- Reset values: TX = 1, READY = 1, BUSY = 0, DONE = 0.
- Start latency from IDLE:
  - Write accepted at edge E0.
  - Frame start at edge E1: TX falls and BUSY rises after E1; READY returns to 1 after E1.
- Every bit, including start and stop, lasts exactly BIT_TIME cycles.
- Frame length is 10·BIT_TIME cycles without parity and 11·BIT_TIME cycles with parity.
- DONE is high for exactly one cycle, starting at the edge that ends the stop bit.
- Back-to-back frames: if hold_full is set at the end of the stop bit, the next start bit begins on the same edge. This gives zero idle cycles between frames, and DONE and the new start bit coincide.
- TX changes only on rising edges (registered, glitch-free); its only asynchronous change is to 1 on RESET.

## Test plan

- **Reset values.** Hold RESET, then release it. TX = 1, READY = 1, BUSY = 0 and DONE = 0 throughout, with no activity over 100 cycles.
- **8-N-1 frame.** BIT_TIME = 8, PARITY_EN = 0, write 0xA5. TX carries 0, then bits 1,0,1,0,0,1,0,1 (LSB first), then 1, each held 8 cycles. DONE pulses once, 80 cycles after TX falls.
- **Parity.** BIT_TIME = 8, PARITY_EN = 1.
  - Write 0x07 with PARITY_ODD = 0: parity bit = 1.
  - Write 0x07 with PARITY_ODD = 1: parity bit = 0.
  - Toggling PARITY_ODD mid-frame does not change the frame's parity bit.
  - Frame length is 88 cycles.
- **Back-to-back frames.** Write 0x55, then write 0xC3 when READY next rises. Two contiguous frames with no idle cycle between them. A third write while READY = 0 is dropped, and exactly two DONE pulses occur.
- **Mid-frame reset.** Assert RESET during data bit 3 of a frame. TX = 1 immediately (asynchronously), READY = 1, and no DONE. A fresh write of 0x3C after release transmits correctly.
- **Loopback.** Connect TX to the UART receiver with matching BIT_TIME and parity settings; send 0x00, 0xFF and 0x5A in every parity mode. The receiver reports the same bytes with PARITY_ERR = 0.
